// File: rtl/lts_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// lts_capture_ctrl_if
// AXI-Stream style bundle carrying {Q, I} samples between the sample path and
// the LTS capture controller.
//   tvalid  : beat valid (source -> sink)
//   tready  : sink ready (sink -> source)
//   tdata   : 2*DATA_W sample {Q, I}, I on the LSBs
//   tlast   : last beat of a frame
//   tuser   : LTS symbol index of the beat
// modport master drives a stream, modport slave receives one.
// ---------------------------------------------------------------------------
interface lts_capture_ctrl_if #(
    parameter int DATA_W = 16
);
    logic                  tvalid;
    logic                  tready;
    logic [2*DATA_W-1:0]   tdata;
    logic                  tlast;
    logic [2:0]            tuser;

    modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/lts_capture_ctrl.sv
// ---------------------------------------------------------------------------
// lts_capture_ctrl
// Power trigger, preamble search FSM, LTS search timeout and capture of
// NUM_SYM LTS symbols, emitted as one packet per detected frame.
//   clk_in / rst_n_in : clock, asynchronous active-low reset
//   s_axis            : input sample stream (slave)
//   m_axis            : captured LTS stream, tuser = symbol index (master)
//   sts_detect_in     : short preamble detected (qualified by accepted beat)
//   lts_start_in      : accepted beat is LTS symbol 0, sample 0
//   power_thresh_in   : average magnitude threshold
//   state_out         : 0 IDLE, 1 SEARCH_STS, 2 SEARCH_LTS, 3 CAPTURE
//   frames_out        : saturating count of completed frames
//   timeouts_out      : saturating count of LTS search timeouts
//
// state      | meaning
// IDLE       | waiting for the average power to reach the threshold
// SEARCH_STS | power present, waiting for the short preamble strobe
// SEARCH_LTS | waiting for the LTS start marker, bounded by TIMEOUT beats
// CAPTURE    | forwarding NUM_SYM*SYM_LEN samples to the output register
// ---------------------------------------------------------------------------
module lts_capture_ctrl #(
    parameter int DATA_W   = 16,
    parameter int SYM_LEN  = 64,
    parameter int NUM_SYM  = 2,
    parameter int PWR_LOG2 = 4,
    parameter int TIMEOUT  = 320
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    lts_capture_ctrl_if.slave    s_axis,
    lts_capture_ctrl_if.master   m_axis,
    input  logic                 sts_detect_in,
    input  logic                 lts_start_in,
    input  logic [DATA_W:0]      power_thresh_in,
    output logic [1:0]           state_out,
    output logic [15:0]          frames_out,
    output logic [15:0]          timeouts_out
);
    localparam int MAG_W  = DATA_W + 1;
    localparam int WIN    = 1 << PWR_LOG2;
    localparam int SUM_W  = MAG_W + PWR_LOG2;
    localparam int SAMP_W = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SYM_LEN - 1);
    localparam logic [2:0]        SYM_LAST  = 3'(NUM_SYM - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEARCH_STS = 2'd1,
        SEARCH_LTS = 2'd2,
        CAPTURE    = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [TO_W-1:0]     r_to_cnt, w_to_nxt;
    logic [SAMP_W-1:0]   r_samp, w_samp_nxt;
    logic [2:0]          r_sym, w_sym_nxt;
    logic                w_cap_beat, w_frame_inc, w_to_inc;

    logic [MAG_W-1:0]    r_win [WIN];
    logic [SUM_W-1:0]    r_sum;
    logic [MAG_W-1:0]    w_mag;
    logic                w_power_ok;

    logic                r_m_valid, r_m_last;
    logic [2*DATA_W-1:0] r_m_data;
    logic [2:0]          r_m_user;
    logic [15:0]         r_frames, r_timeouts;

    logic                w_out_free, w_ready, w_acc, w_last;
    logic                w_unused;

    // |x| with the most negative code clamped so the result fits DATA_W-1 bits
    function automatic logic [DATA_W-1:0] f_abs(input logic [DATA_W-1:0] x);
        if (!x[DATA_W-1])
            return x;
        else if (x == {1'b1, {(DATA_W-1){1'b0}}})
            return {1'b0, {(DATA_W-1){1'b1}}};
        else
            return -x;
    endfunction

    assign w_mag      = {1'b0, f_abs(s_axis.tdata[DATA_W-1:0])}
                      + {1'b0, f_abs(s_axis.tdata[2*DATA_W-1:DATA_W])};
    assign w_power_ok = r_sum[SUM_W-1:PWR_LOG2] >= power_thresh_in;

    // The beat carrying lts_start_in is the first captured sample, so it is
    // throttled by the output register like every CAPTURE beat.
    assign w_out_free = !r_m_valid || m_axis.tready;
    assign w_ready    = ((r_state == CAPTURE) || ((r_state == SEARCH_LTS) && lts_start_in))
                      ? w_out_free : 1'b1;
    assign w_acc      = s_axis.tvalid && w_ready;
    assign w_last     = (r_samp == SAMP_LAST) && (r_sym == SYM_LAST);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int k = 0; k < WIN; k++) r_win[k] <= '0;
            r_sum <= '0;
        end else if (w_acc) begin
            r_win[0] <= w_mag;
            for (int k = 1; k < WIN; k++) r_win[k] <= r_win[k-1];
            r_sum <= r_sum + SUM_W'(w_mag) - SUM_W'(r_win[WIN-1]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_to_nxt    = r_to_cnt;
        w_samp_nxt  = r_samp;
        w_sym_nxt   = r_sym;
        w_cap_beat  = 1'b0;
        w_frame_inc = 1'b0;
        w_to_inc    = 1'b0;
        if (w_acc) begin
            case (r_state)
                IDLE: begin
                    if (w_power_ok) w_state_nxt = SEARCH_STS;
                end
                SEARCH_STS: begin
                    if (!w_power_ok) begin
                        w_state_nxt = IDLE;
                    end else if (sts_detect_in) begin
                        w_state_nxt = SEARCH_LTS;
                        w_to_nxt    = '0;
                    end
                end
                SEARCH_LTS: begin
                    if (lts_start_in) begin
                        w_cap_beat  = 1'b1;
                        w_state_nxt = CAPTURE;
                    end else if (!w_power_ok) begin
                        w_state_nxt = IDLE;
                    end else if (r_to_cnt == TO_LAST) begin
                        w_state_nxt = IDLE;
                        w_to_inc    = 1'b1;
                    end else begin
                        w_to_nxt = r_to_cnt + TO_W'(1);
                    end
                end
                default: w_cap_beat = 1'b1;
            endcase
            if (w_cap_beat) begin
                if (w_last) begin
                    w_state_nxt = IDLE;
                    w_frame_inc = 1'b1;
                    w_samp_nxt  = '0;
                    w_sym_nxt   = '0;
                end else if (r_samp == SAMP_LAST) begin
                    w_samp_nxt = '0;
                    w_sym_nxt  = r_sym + 3'd1;
                end else begin
                    w_samp_nxt = r_samp + SAMP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= IDLE;
            r_to_cnt   <= '0;
            r_samp     <= '0;
            r_sym      <= '0;
            r_frames   <= '0;
            r_timeouts <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_to_cnt <= w_to_nxt;
            r_samp   <= w_samp_nxt;
            r_sym    <= w_sym_nxt;
            if (w_frame_inc && (r_frames != 16'hFFFF))   r_frames   <= r_frames + 16'd1;
            if (w_to_inc && (r_timeouts != 16'hFFFF))    r_timeouts <= r_timeouts + 16'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
            r_m_user  <= '0;
        end else if (w_cap_beat) begin
            r_m_valid <= 1'b1;
            r_m_last  <= w_last;
            r_m_data  <= s_axis.tdata;
            r_m_user  <= r_sym;
        end else if (m_axis.tready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign s_axis.tready = w_ready;
    assign m_axis.tvalid = r_m_valid;
    assign m_axis.tlast  = r_m_last;
    assign m_axis.tdata  = r_m_data;
    assign m_axis.tuser  = r_m_user;
    assign state_out     = r_state;
    assign frames_out    = r_frames;
    assign timeouts_out  = r_timeouts;

    // input-side framing fields carry no meaning for this block
    assign w_unused = ^{s_axis.tlast, s_axis.tuser};
endmodule

// File: tb/tb_lts_capture_ctrl.sv
module tb_lts_capture_ctrl;
    localparam int DATA_W   = 16;
    localparam int SYM_LEN  = 64;
    localparam int NUM_SYM  = 2;
    localparam int PWR_LOG2 = 4;
    localparam int TIMEOUT  = 320;
    localparam int FRAME    = SYM_LEN * NUM_SYM;
    localparam int WIN      = 1 << PWR_LOG2;
    localparam int MAXB     = 1024;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  u;
        logic        l;
    } beat_t;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          sts_detect_in, lts_start_in;
    logic [DATA_W:0] power_thresh_in;
    logic [1:0]    state_out;
    logic [15:0]   frames_out, timeouts_out;

    lts_capture_ctrl_if #(.DATA_W(DATA_W)) s_if ();
    lts_capture_ctrl_if #(.DATA_W(DATA_W)) m_if ();

    lts_capture_ctrl #(
        .DATA_W(DATA_W), .SYM_LEN(SYM_LEN), .NUM_SYM(NUM_SYM),
        .PWR_LOG2(PWR_LOG2), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .s_axis          (s_if),
        .m_axis          (m_if),
        .sts_detect_in   (sts_detect_in),
        .lts_start_in    (lts_start_in),
        .power_thresh_in (power_thresh_in),
        .state_out       (state_out),
        .frames_out      (frames_out),
        .timeouts_out    (timeouts_out)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int miscompares = 0;

    // reference model
    int    mdl_mode, mdl_occ, mdl_k, mdl_lts_beats, mdl_frames, mdl_tos;
    int    win_q[$];
    beat_t exp_q[$];

    // stimulus plan and observations
    bit    sts_mark[MAXB];
    bit    lts_mark[MAXB];
    int    zero_from;
    bit    const_data, sat_data, rnd_v, rnd_r;
    int    acc_cnt, out_cnt, tlast_cnt, tuser1_cnt, lts_cycles, idle_acc;
    bit    seen_lts, prev_stall;
    logic [31:0] prev_data;

    function automatic logic [31:0] sample(input int b);
        int ival;
        logic [15:0] iv, qv;
        if (sat_data) return 32'h8000_8000;
        if (b >= zero_from) return 32'h0;
        if (const_data) return {16'd1000, 16'd1000};
        ival = 1000 + (b % 2000);
        if (b % 2 == 1) ival = -ival;
        iv = 16'(ival);
        qv = 16'(-1000);
        return {qv, iv};
    endfunction

    function automatic int mag_of(input logic [31:0] d);
        int iv, qv;
        iv = int'($signed(d[15:0]));
        qv = int'($signed(d[31:16]));
        iv = (iv < 0) ? -iv : iv;
        qv = (qv < 0) ? -qv : qv;
        if (iv > 32767) iv = 32767;
        if (qv > 32767) qv = 32767;
        return iv + qv;
    endfunction

    task automatic mdl_reset();
        mdl_mode = 0; mdl_occ = 0; mdl_k = 0; mdl_lts_beats = 0;
        mdl_frames = 0; mdl_tos = 0;
        win_q.delete();
        for (int i = 0; i < WIN; i++) win_q.push_back(0);
        exp_q.delete();
        for (int i = 0; i < MAXB; i++) begin
            sts_mark[i] = 1'b0;
            lts_mark[i] = 1'b0;
        end
        zero_from = 1 << 30;
        const_data = 0; sat_data = 0; rnd_v = 0; rnd_r = 0;
        acc_cnt = 0; out_cnt = 0; tlast_cnt = 0; tuser1_cnt = 0;
        lts_cycles = 0; idle_acc = -1; seen_lts = 0; prev_stall = 0;
        prev_data = '0;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = '0;
        m_if.tready = 1'b1;
        sts_detect_in = 1'b0; lts_start_in = 1'b0;
        power_thresh_in = 17'd1500;
        repeat (3) @(negedge clk_in);
        mdl_reset();
        rst_n_in = 1'b1;
    endtask

    // One clock of stimulus, scoreboard and model update; entered and left on negedge.
    task automatic cycle(input bit want_v);
        bit v, mr, sts, lts, exp_rdy, acc, ok, cap;
        int idx, sum, new_occ;
        logic [31:0] d;
        beat_t e;
        idx = (acc_cnt < MAXB) ? acc_cnt : MAXB - 1;
        v   = want_v && (!rnd_v || ($urandom_range(0, 3) != 0));
        mr  = !rnd_r || ($urandom_range(0, 1) == 1);
        d   = sample(acc_cnt);
        sts = sts_mark[idx];
        lts = lts_mark[idx];
        s_if.tvalid = v; s_if.tdata = d;
        sts_detect_in = sts; lts_start_in = lts;
        m_if.tready = mr;
        #1;
        exp_rdy = ((mdl_mode == 3) || ((mdl_mode == 2) && lts)) ? (!mdl_occ || mr) : 1'b1;

        vectors++;
        if (state_out !== 2'(mdl_mode)) begin
            miscompares++;
            $display("FAIL state: got %0d want %0d (beat %0d)", state_out, mdl_mode, acc_cnt);
        end
        vectors++;
        if (frames_out !== 16'(mdl_frames) || timeouts_out !== 16'(mdl_tos)) begin
            miscompares++;
            $display("FAIL counters: got frames %0d timeouts %0d want %0d %0d",
                     frames_out, timeouts_out, mdl_frames, mdl_tos);
        end
        vectors++;
        if (m_if.tvalid !== 1'(mdl_occ)) begin
            miscompares++;
            $display("FAIL m_tvalid: got %b want %0d (beat %0d)", m_if.tvalid, mdl_occ, acc_cnt);
        end
        vectors++;
        if (s_if.tready !== exp_rdy) begin
            miscompares++;
            $display("FAIL s_tready: got %b want %b (beat %0d)", s_if.tready, exp_rdy, acc_cnt);
        end
        if (mdl_occ != 0 && exp_q.size() > 0) begin
            vectors++;
            if (m_if.tdata !== exp_q[0].d || m_if.tuser !== exp_q[0].u || m_if.tlast !== exp_q[0].l) begin
                miscompares++;
                $display("FAIL out_beat: got data %h user %0d last %b want %h %0d %b",
                         m_if.tdata, m_if.tuser, m_if.tlast, exp_q[0].d, exp_q[0].u, exp_q[0].l);
            end
        end
        if (prev_stall) begin
            vectors++;
            if (m_if.tdata !== prev_data) begin
                miscompares++;
                $display("FAIL stall_hold: got %h want %h", m_if.tdata, prev_data);
            end
        end
        prev_stall = m_if.tvalid && !mr;
        prev_data  = m_if.tdata;

        if (state_out == 2'd2) begin
            lts_cycles++;
            seen_lts = 1'b1;
        end
        if (seen_lts && state_out == 2'd0 && idle_acc < 0) idle_acc = acc_cnt;
        if (m_if.tvalid && mr) begin
            out_cnt++;
            if (m_if.tlast) tlast_cnt++;
            if (m_if.tuser == 3'd1) tuser1_cnt++;
        end

        acc = v && s_if.tready;
        new_occ = (mdl_occ != 0 && !mr) ? 1 : 0;
        if (mdl_occ != 0 && mr && exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) begin
            sum = 0;
            foreach (win_q[i]) sum += win_q[i];
            ok  = (sum / WIN) >= int'(power_thresh_in);
            cap = 1'b0;
            case (mdl_mode)
                0: if (ok) mdl_mode = 1;
                1: begin
                    if (!ok) mdl_mode = 0;
                    else if (sts) begin
                        mdl_mode = 2;
                        mdl_lts_beats = 0;
                    end
                end
                2: begin
                    if (lts) begin
                        cap = 1'b1;
                        mdl_mode = 3;
                    end else if (!ok) mdl_mode = 0;
                    else if (mdl_lts_beats == TIMEOUT - 1) begin
                        mdl_mode = 0;
                        if (mdl_tos < 65535) mdl_tos++;
                    end else mdl_lts_beats++;
                end
                default: cap = 1'b1;
            endcase
            if (cap) begin
                e.d = d;
                e.u = 3'(mdl_k / SYM_LEN);
                e.l = (mdl_k == FRAME - 1);
                exp_q.push_back(e);
                new_occ = 1;
                mdl_k++;
                if (mdl_k == FRAME) begin
                    mdl_k = 0;
                    mdl_mode = 0;
                    if (mdl_frames < 65535) mdl_frames++;
                end
            end
            win_q.push_back(mag_of(d));
            void'(win_q.pop_front());
            acc_cnt++;
        end
        mdl_occ = new_occ;
        @(negedge clk_in);
    endtask

    task automatic stream(input int n_beats, input bit drain, input int max_cyc);
        int cyc;
        cyc = 0;
        while ((acc_cnt < n_beats || (drain && (mdl_occ != 0 || exp_q.size() > 0))) && cyc < max_cyc) begin
            cycle(acc_cnt < n_beats);
            cyc++;
        end
        if (cyc >= max_cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL stream_bound: got %0d beats after %0d cycles want %0d", acc_cnt, cyc, n_beats);
        end
        if (drain) repeat (3) cycle(1'b0);
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = '0;
        m_if.tready = 1'b0; sts_detect_in = 1'b0; lts_start_in = 1'b0;
        power_thresh_in = 17'd1500;
        repeat (2) @(negedge clk_in);
        #1;
        vectors++;
        if (m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0 || m_if.tuser !== 3'd0 || m_if.tdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_m_axis: got v%b l%b u%0d d%h want all 0",
                     m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata);
        end
        vectors++;
        if (s_if.tready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_s_tready: got %b want 1", s_if.tready);
        end
        vectors++;
        if (state_out !== 2'd0 || frames_out !== 16'd0 || timeouts_out !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_state: got st %0d fr %0d to %0d want 0 0 0",
                     state_out, frames_out, timeouts_out);
        end
        @(negedge clk_in);
        do_reset();
    endtask

    task automatic test_capture();
        do_reset();
        const_data = 1;
        sts_mark[40] = 1'b1;
        lts_mark[100] = 1'b1;
        stream(240, 1'b1, 2000);
        vectors++;
        if (out_cnt != FRAME || tlast_cnt != 1 || tuser1_cnt != SYM_LEN) begin
            miscompares++;
            $display("FAIL capture_counts: got out %0d tlast %0d sym1 %0d want %0d 1 %0d",
                     out_cnt, tlast_cnt, tuser1_cnt, FRAME, SYM_LEN);
        end
        vectors++;
        if (frames_out !== 16'd1) begin
            miscompares++;
            $display("FAIL capture_frames: got %0d want 1", frames_out);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        const_data = 1;
        sts_mark[40] = 1'b1;
        stream(420, 1'b1, 2000);
        vectors++;
        if (lts_cycles != TIMEOUT) begin
            miscompares++;
            $display("FAIL timeout_len: got %0d cycles in SEARCH_LTS want %0d", lts_cycles, TIMEOUT);
        end
        vectors++;
        if (timeouts_out !== 16'd1 || out_cnt != 0 || frames_out !== 16'd0) begin
            miscompares++;
            $display("FAIL timeout_counts: got to %0d out %0d fr %0d want 1 0 0",
                     timeouts_out, out_cnt, frames_out);
        end
    endtask

    task automatic test_power_drop();
        do_reset();
        sts_mark[40] = 1'b1;
        zero_from = 41;
        stream(80, 1'b1, 1000);
        vectors++;
        if (idle_acc < 42 || idle_acc > 57) begin
            miscompares++;
            $display("FAIL drop_idle: got IDLE seen at beat %0d want within 16 beats of 41", idle_acc);
        end
        vectors++;
        if (out_cnt != 0 || frames_out !== 16'd0 || timeouts_out !== 16'd0) begin
            miscompares++;
            $display("FAIL drop_counts: got out %0d fr %0d to %0d want 0 0 0",
                     out_cnt, frames_out, timeouts_out);
        end
    endtask

    task automatic test_random_stall();
        do_reset();
        rnd_v = 1;
        rnd_r = 1;
        sts_mark[40] = 1'b1;
        lts_mark[100] = 1'b1;
        stream(240, 1'b1, 5000);
        vectors++;
        if (out_cnt != FRAME || tlast_cnt != 1 || frames_out !== 16'd1) begin
            miscompares++;
            $display("FAIL stall_counts: got out %0d tlast %0d fr %0d want %0d 1 1",
                     out_cnt, tlast_cnt, frames_out, FRAME);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        sat_data = 1;
        power_thresh_in = 17'd65535;
        stream(24, 1'b0, 200);
        vectors++;
        if (state_out !== 2'd0) begin
            miscompares++;
            $display("FAIL sat_below: got state %0d want 0", state_out);
        end
        power_thresh_in = 17'd65534;
        stream(26, 1'b0, 200);
        vectors++;
        if (state_out !== 2'd1) begin
            miscompares++;
            $display("FAIL sat_at: got state %0d want 1", state_out);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sts_mark[40] = 1'b1;
        lts_mark[100] = 1'b1;
        stream(240, 1'b1, 2000);
        sts_mark[250] = 1'b1;
        lts_mark[300] = 1'b1;
        stream(331, 1'b0, 1000);
        vectors++;
        if (m_if.tvalid !== 1'b1 || frames_out !== 16'd1) begin
            miscompares++;
            $display("FAIL mid_before: got v %b fr %0d want 1 1", m_if.tvalid, frames_out);
        end
        #2 rst_n_in = 1'b0;
        #1;
        vectors++;
        if (m_if.tvalid !== 1'b0 || state_out !== 2'd0 || frames_out !== 16'd0 || timeouts_out !== 16'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got v %b st %0d fr %0d to %0d want 0 0 0 0",
                     m_if.tvalid, state_out, frames_out, timeouts_out);
        end
        @(negedge clk_in);
        do_reset();
        sts_mark[40] = 1'b1;
        lts_mark[100] = 1'b1;
        stream(240, 1'b1, 2000);
        vectors++;
        if (out_cnt != FRAME || tlast_cnt != 1 || frames_out !== 16'd1) begin
            miscompares++;
            $display("FAIL mid_fresh: got out %0d tlast %0d fr %0d want %0d 1 1",
                     out_cnt, tlast_cnt, frames_out, FRAME);
        end
    endtask

    task automatic test_priority();
        do_reset();
        sts_mark[40] = 1'b1;
        zero_from = 41;
        lts_mark[46] = 1'b1;
        stream(46 + FRAME + 20, 1'b1, 2000);
        vectors++;
        if (out_cnt != FRAME || frames_out !== 16'd1) begin
            miscompares++;
            $display("FAIL lts_over_power: got out %0d fr %0d want %0d 1", out_cnt, frames_out, FRAME);
        end
        do_reset();
        sts_mark[40] = 1'b1;
        lts_mark[40] = 1'b1;
        lts_mark[60] = 1'b1;
        stream(41, 1'b0, 200);
        vectors++;
        if (state_out !== 2'd2 || m_if.tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL sts_with_lts: got st %0d v %b want 2 0", state_out, m_if.tvalid);
        end
        stream(61 + FRAME + 5, 1'b1, 2000);
        vectors++;
        if (out_cnt != FRAME || frames_out !== 16'd1) begin
            miscompares++;
            $display("FAIL sts_with_lts_frame: got out %0d fr %0d want %0d 1", out_cnt, frames_out, FRAME);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        sts_mark[40] = 1'b1;
        lts_mark[100] = 1'b1;
        sts_mark[229] = 1'b1;
        lts_mark[230] = 1'b1;
        stream(400, 1'b1, 3000);
        vectors++;
        if (out_cnt != 2 * FRAME || tlast_cnt != 2 || frames_out !== 16'd2) begin
            miscompares++;
            $display("FAIL back_to_back: got out %0d tlast %0d fr %0d want %0d 2 2",
                     out_cnt, tlast_cnt, frames_out, 2 * FRAME);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mdl_reset();
        test_reset();
        test_capture();
        test_timeout();
        test_power_drop();
        test_random_stall();
        test_saturation();
        test_reset_mid();
        test_priority();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
